// File: rtl/ram_scan.sv
// ram_scan: sweeps a 16x8 RAM read port over all addresses, holds each one for DWELL cycles, and drives address/data onto 7-seg displays.
// Latency: start -> first capture takes 1 + RD_LAT cycles; each address takes 1 + RD_LAT + DWELL cycles while not paused.
// Backpressure: none downstream; pause freezes the dwell count only in SHOW, and an issued read always completes.
// Optional feature: define RAM_SCAN_ADDR_HEX_EN to show cur_addr on hex2; otherwise hex2 stays blank.
module ram_scan #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DWELL  = 25_000_000,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic              loop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [DATA_W-1:0] rddata,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_data,
    output logic              valid,
    output logic              done,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2
);

    localparam int DW_W  = (DWELL  > 1) ? $clog2(DWELL)  : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [6:0]        BLANK      = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        SHOW
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_data_q, cur_data_d;
    logic                done_q, done_d;
    logic                blank;

    // Active-low segments {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // State and datapath registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dwell_q    <= '0;
            lat_q      <= '0;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dwell_q    <= dwell_d;
            lat_q      <= lat_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            done_q     <= done_d;
        end
    end

    // Next-state: issue the address, wait out the RAM latency, capture, then dwell.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dwell_d    = dwell_q;
        lat_d      = lat_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    cur_data_d = rddata;
                    cur_addr_d = addr_q;
                    dwell_d    = '0;
                    state_d    = SHOW;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            SHOW: begin
                if (!pause) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (addr_q != ADDR_MAX) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ISSUE;
                        end else if (loop) begin
                            addr_d  = '0;
                            state_d = ISSUE;
                        end else begin
                            // Single sweep finished: done lines up with the IDLE cycle.
                            addr_d  = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdaddr   = addr_q;
    assign cur_addr = cur_addr_q;
    assign cur_data = cur_data_q;
    assign valid    = (state_q == SHOW);
    assign done     = done_q;

    // Displays go dark in IDLE; captured values stay latched underneath.
    assign blank = (state_q == IDLE);
    assign hex0  = blank ? BLANK : seg7(cur_data_q[3:0]);
    assign hex1  = blank ? BLANK : seg7(cur_data_q[7:4]);

`ifdef RAM_SCAN_ADDR_HEX_EN
    assign hex2 = blank ? BLANK : seg7(4'(cur_addr_q));
`else
    assign hex2 = BLANK;
`endif

endmodule

// File: tb/tb_ram_scan.sv
// tb_ram_scan: checks ram_scan with DWELL=4 at RD_LAT=1 (instance a) and RD_LAT=2 (instance b).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_ram_scan;
    localparam int DWELL = 4;

`ifdef RAM_SCAN_ADDR_HEX_EN
    localparam bit ADDR_HEX = 1'b1;
`else
    localparam bit ADDR_HEX = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clrn;
    logic       start_a, loop_a, pause_a, valid_a, done_a;
    logic [3:0] rdaddr_a, cur_addr_a;
    logic [7:0] rddata_a, cur_data_a;
    logic [6:0] h0a, h1a, h2a;
    logic       start_b, loop_b, pause_b, valid_b, done_b;
    logic [3:0] rdaddr_b, cur_addr_b;
    logic [7:0] rddata_b, cur_data_b, pipe_b;
    logic [6:0] h0b, h1b, h2b;

    logic [7:0] ram [16];

    ram_scan #(.ADDR_W(4), .DATA_W(8), .DWELL(DWELL), .RD_LAT(1)) dut_a (
        .clk(clk), .clrn(clrn), .start(start_a), .loop(loop_a), .pause(pause_a),
        .rdaddr(rdaddr_a), .rddata(rddata_a), .cur_addr(cur_addr_a), .cur_data(cur_data_a),
        .valid(valid_a), .done(done_a), .hex0(h0a), .hex1(h1a), .hex2(h2a)
    );

    ram_scan #(.ADDR_W(4), .DATA_W(8), .DWELL(DWELL), .RD_LAT(2)) dut_b (
        .clk(clk), .clrn(clrn), .start(start_b), .loop(loop_b), .pause(pause_b),
        .rdaddr(rdaddr_b), .rddata(rddata_b), .cur_addr(cur_addr_b), .cur_data(cur_data_b),
        .valid(valid_b), .done(done_b), .hex0(h0b), .hex1(h1b), .hex2(h2b)
    );

    // RAM read ports: one and two registered stages.
    always @(posedge clk) begin
        rddata_a <= ram[rdaddr_a];
        pipe_b   <= ram[rdaddr_b];
        rddata_b <= pipe_b;
    end

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [6:0] seg;
    } vec_t;

    vec_t       tbl [16];
    logic [6:0] seg_tab [16];
    int         total = 0;
    int         bad = 0;
    int         rel = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after relative edge k of the current sequence.
    task automatic goto(input int k);
        repeat (k - rel) @(posedge clk);
        #1;
        rel = k;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdaddr_a"}, rdaddr_a, 0);
        check({tag, "_cur_addr_a"}, cur_addr_a, 0);
        check({tag, "_cur_data_a"}, cur_data_a, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_done_a"}, done_a, 0);
        check({tag, "_hex_a"}, {h2a, h1a, h0a}, {3{7'h7F}});
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_hex_b"}, {h2b, h1b, h0b}, {3{7'h7F}});
    endtask

    // Single sweep on one instance, checked entry by entry against the table.
    task automatic sweep(input bit use_b, input int lat);
        int period;
        int cap;
        period = 1 + lat + DWELL;
        if (use_b) begin
            loop_b = 1'b0; pause_b = 1'b1; start_b = 1'b1;
        end else begin
            loop_a = 1'b0; pause_a = 1'b0; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        rel = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap = period * i + 1 + lat;
            if (i > 0) begin
                goto(cap - 1);
                check("hold_addr", use_b ? cur_addr_b : cur_addr_a, tbl[i-1].addr);
                check("hold_valid", use_b ? valid_b : valid_a, 0);
            end
            goto(cap);
            // pause was held through ISSUE/WAIT of address 0 on instance b
            pause_b = 1'b0;
            check("cap_addr", use_b ? cur_addr_b : cur_addr_a, tbl[i].addr);
            check("cap_data", use_b ? cur_data_b : cur_data_a, tbl[i].data);
            check("cap_valid", use_b ? valid_b : valid_a, 1);
            check("hex0", use_b ? h0b : h0a, tbl[i].seg);
            check("hex1", use_b ? h1b : h1a, tbl[i].seg);
            check("hex2", use_b ? h2b : h2a, ADDR_HEX ? tbl[i].seg : 7'h7F);
        end
        goto(16 * period - 1);
        check("done_early", use_b ? done_b : done_a, 0);
        goto(16 * period);
        check("done_pulse", use_b ? done_b : done_a, 1);
        check("done_valid", use_b ? valid_b : valid_a, 0);
        check("done_blank", use_b ? h0b : h0a, 7'h7F);
        goto(16 * period + 1);
        check("done_one_cycle", use_b ? done_b : done_a, 0);
        goto(16 * period + 3);
        check("stay_idle", use_b ? valid_b : valid_a, 0);
    endtask

    initial begin
        bit         seen_done;
        bit         in_show;
        int         gap;
        int         cnt;
        logic [3:0] exp_addr;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) begin
            ram[i] = 8'(17 * i);
            tbl[i] = '{addr: 4'(i), data: 8'(17 * i), seg: seg_tab[i]};
        end

        clrn = 1'b0;
        start_a = 1'b0; loop_a = 1'b0; pause_a = 1'b0;
        start_b = 1'b0; loop_b = 1'b0; pause_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        clrn = 1'b1;

        // Single sweep, RD_LAT=1: period 6, done 96 cycles after first ISSUE.
        sweep(1'b0, 1);

        // Looping sweep with a 10-cycle pause on address 5.
        loop_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        rel = 0;
        start_a = 1'b0;
        goto(32);
        check("p_cap5", cur_addr_a, 5);
        check("p_valid5", valid_a, 1);
        goto(33);
        pause_a = 1'b1;
        goto(43);
        pause_a = 1'b0;
        check("p_frozen", {valid_a, 4'(cur_addr_a)}, {1'b1, 4'h5});
        goto(45);
        check("p_last_show", {valid_a, 4'(cur_addr_a)}, {1'b1, 4'h5});
        goto(46);
        check("p_left_show", valid_a, 0);
        check("p_hold5", cur_addr_a, 5);
        goto(48);
        check("p_cap6", cur_addr_a, 6);
        check("p_data6", cur_data_a, 8'h66);
        seen_done = 1'b0;
        for (int k = 49; k <= 108; k++) begin
            goto(k);
            if (done_a) seen_done = 1'b1;
            if (k == 107) check("l_hold15", cur_addr_a, 15);
        end
        check("l_wrap_addr", cur_addr_a, 0);
        check("l_wrap_data", cur_data_a, 8'h00);
        check("l_wrap_valid", valid_a, 1);
        check("l_no_done", seen_done, 0);

        // Reset held 3 cycles mid-sweep.
        goto(111);
        clrn = 1'b0;
        goto(112);
        check_reset("rst1");
        goto(114);
        clrn = 1'b1;
        check_reset("rst3");
        goto(116);
        check("rst_idle", {valid_a, h0a}, {1'b0, 7'h7F});

        // Randomized pause against a dwell/sequence model, looping forever.
        loop_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        in_show = 1'b0;
        gap = 0;
        cnt = 0;
        exp_addr = 4'h0;
        seen_done = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (done_a) seen_done = 1'b1;
            if (valid_a) begin
                if (!in_show) begin
                    check("r_gap", gap, 2);
                    check("r_addr", cur_addr_a, exp_addr);
                    check("r_data", cur_data_a, ram[exp_addr]);
                    in_show = 1'b1;
                    cnt = 0;
                end
            end else begin
                if (in_show) begin
                    check("r_dwell", cnt, DWELL);
                    in_show = 1'b0;
                    gap = 0;
                    exp_addr = exp_addr + 4'h1;
                end
                gap++;
            end
            pause_a = ($urandom_range(0, 3) == 0);
            if (valid_a && !pause_a) cnt++;
            @(posedge clk);
            #1;
        end
        check("r_no_done", seen_done, 0);
        pause_a = 1'b0;
        clrn = 1'b0;
        @(posedge clk);
        #1;
        check_reset("rst_rand");
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // RD_LAT=2: period 7, pause held during the first ISSUE/WAIT.
        sweep(1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_scan.md
# ram_scan

Sequential read-out stage for the 16×8 experiment RAM: it sweeps the RAM's read port through addresses 0..15 and holds each address for a programmable dwell time. It captures the returned byte and drives the address and data onto the board's 7-segment displays. It sits directly downstream of the dual-port RAM, owns the RAM's read address, consumes its `q`, and replaces single-address display with a self-running memory dump.

## Interface
Parameters:
- `ADDR_W`, 4, RAM address width; the sweep covers 0..2^ADDR_W−1.
- `DATA_W`, 8, RAM data width; fixed at 8 for the two-digit display.
- `DWELL`, 25_000_000, clock cycles each address is displayed (≥1).
- `RD_LAT`, 1, RAM read latency in cycles from address to valid `q` (≥1).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `clrn` input 1: reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `start` input 1: level; sampled in IDLE to begin a sweep.
- `loop` input 1: 1 means the sweep repeats forever, 0 means a single sweep then IDLE.
- `pause` input 1: freezes the dwell counter while in SHOW.
- `rdaddr` output ADDR_W: read address to the RAM.
- `rddata` input DATA_W: RAM `q`.
- `cur_addr` output ADDR_W: address currently displayed.
- `cur_data` output DATA_W: captured byte for `cur_addr`.
- `valid` output 1: high while in SHOW.
- `done` output 1: one-cycle pulse at the end of a single sweep.
- `hex0` output 7: active-low segments for `cur_data[3:0]`.
- `hex1` output 7: active-low segments for `cur_data[7:4]`.
- `hex2` output 7: active-low segments for `cur_addr`.

## Operation
- States: IDLE, ISSUE, WAIT, SHOW.
- IDLE:
  - `addr` register = 0 and `valid` = 0.
  - `hex0`..`hex2` = 7'h7F (blank).
  - If `start`=1, go to ISSUE.
- ISSUE (1 cycle): `rdaddr`=`addr`. The `rdaddr` output is driven from the `addr` register in every state. Go to WAIT and clear the latency counter.
- WAIT (RD_LAT cycles):
  - On the edge ending the RD_LAT-th WAIT cycle, capture `rddata` into `cur_data` and `addr` into `cur_addr`.
  - Clear the dwell counter and go to SHOW.
- SHOW:
  - The dwell counter increments each cycle in which `pause`=0. It holds while `pause`=1.
  - When the counter = DWELL−1 and `pause`=0:
    - If `addr` is not at its maximum: increment `addr` and go to ISSUE.
    - If `addr` is at its maximum and `loop`=1: wrap `addr` to 0 and go to ISSUE.
    - If `addr` is at its maximum and `loop`=0: set `addr`=0, pulse `done` for one cycle, and go to IDLE.
- `cur_addr`/`cur_data` keep their last captured value through ISSUE and WAIT, so the display does not flicker. In IDLE the hex outputs are blanked, but the registers keep their values.
- `start` is ignored outside IDLE.
- A change of `loop` mid-sweep takes effect at the next wrap decision.
- The hex decoder is combinational from `cur_*` and covers 0–F, with standard DE-board active-low segment order {g,f,e,d,c,b,a}.
- Counter width is ceil(log2(DWELL)) with a minimum of 1. The dwell counter never exceeds DWELL−1.

## Timing
- Reset (`clrn`=0 at an edge), from any state, gives:
  - state = IDLE
  - `addr` = `rdaddr` = `cur_addr` = 0
  - `cur_data` = 0
  - `valid` = 0, `done` = 0
  - all counters = 0
  - `hex0`..`hex2` = 7'h7F
- Reset mid-sweep discards any in-flight read.
- Per-address period with `pause`=0 is 1 + RD_LAT + DWELL cycles.
- Start latency: `start` sampled at edge E0 → ISSUE from E0 → first capture at E0 + 1 + RD_LAT → `valid` high from that edge.
- `done` is asserted for exactly the one cycle following the final SHOW edge, and coincides with entry to IDLE.
- If `start` is still high in that IDLE cycle, a new sweep begins on the next edge.
- `pause` during ISSUE/WAIT has no effect; the read always completes.

## Configuration
- `RAM_SCAN_ADDR_HEX_EN`:
  - Defined: `hex2` shows `cur_addr` as described.
  - Undefined: `hex2` is constant 7'h7F, and the address decoder is not instantiated.
- All other behaviour is identical either way.

## Test plan
All scenarios use DWELL=4, RD_LAT=1, and a RAM model preloaded with mem[i]=8'h10·i+i (e.g. mem[3]=8'h33).
- Reset: hold `clrn`=0 for 3 cycles during a sweep → IDLE, `rdaddr`=0, `valid`=0, all hex = 7'h7F on the next cycle.
- Single sweep (`loop`=0, 1-cycle `start`) → `cur_addr` 0..15 with period 6 cycles, `cur_data`=8'h00, 8'h11, …, 8'hFF. `done` pulses once, 96 cycles after the first ISSUE, then IDLE.
- Loop (`loop`=1) → after address 15, `cur_addr` returns to 0 with `cur_data`=8'h00, and there is no `done` pulse.
- Pause: hold `pause`=1 for 10 cycles while showing address 5 → address 5 is displayed for 14 cycles total, then advances to 6.
- Hex decode: at address 10, `cur_data`=8'hAA → `hex0`=`hex1`=7'b0001000. `hex2` shows "A" with `RAM_SCAN_ADDR_HEX_EN` defined, and 7'h7F without it.
- RD_LAT=2 rerun → period is 7 cycles and captured data is still correct for each address.
